cndm_pcie_us_msi_irq: RTL

- Multi-vector MSI interrupt generator for the CNDM PCIe UltraScale datapath; sits between the NIC's per-queue event sources and the hard PCIe core MSI interface (cfg_interrupt_msi_*).
- Latches interrupt requests per source and arbitrates them round-robin.
- Folds source numbers onto the vectors the host actually granted.
- Issues one MSI at a time with sent/fail/timeout handling, retry backoff and a programmable coalescing holdoff.

---
 rtl/cndm_pcie_us_msi_irq.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/cndm_pcie_us_msi_irq.sv
// Multi-vector MSI generator: latches per-source requests, arbitrates round-robin,
// folds sources onto the granted vectors and drives the UltraScale cfg_interrupt_msi_* port.
module cndm_pcie_us_msi_irq #(
    parameter int IRQ_N       = 32,
    parameter int TIMEOUT     = 1024,
    parameter int RETRY_DELAY = 256,
    parameter int HOLDOFF_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IRQ_N-1:0]     irq_req,
    input  logic [HOLDOFF_W-1:0] holdoff_cycles,
    input  logic                 cfg_interrupt_msi_enable,
    input  logic [2:0]           cfg_interrupt_msi_mmenable,
    output logic [31:0]          cfg_interrupt_msi_int,
    input  logic                 cfg_interrupt_msi_sent,
    input  logic                 cfg_interrupt_msi_fail,
    output logic [31:0]          cfg_interrupt_msi_pending_status,
    output logic                 cfg_interrupt_msi_pending_status_data_enable,
    output logic                 busy,
    output logic                 stat_sent,
    output logic                 stat_fail
);

    localparam int HOLD_MAX = 2 ** HOLDOFF_W;
    localparam int CNT_MAX  = (TIMEOUT > RETRY_DELAY) ?
                              ((TIMEOUT > HOLD_MAX) ? TIMEOUT : HOLD_MAX) :
                              ((RETRY_DELAY > HOLD_MAX) ? RETRY_DELAY : HOLD_MAX);
    localparam int CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, BACKOFF, HOLDOFF} state_t;

    state_t             state_reg;
    logic [IRQ_N-1:0]   pending_reg;
    logic [4:0]         rr_reg;
    logic [4:0]         sel_reg;
    logic [4:0]         vec_reg;
    logic [4:0]         mask_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [31:0]        msi_int_reg;
    logic [31:0]        status_reg;
    logic [31:0]        status_d_reg;
    logic               data_enable_reg;
    logic               stat_sent_reg;
    logic               stat_fail_reg;

    logic [4:0]         fold_mask;
    logic [31:0]        status_next;
    logic [IRQ_N-1:0]   clr_mask;
    logic [IRQ_N-1:0]   fail_set;
    logic               fail_event;
    logic [2*IRQ_N-1:0] pend_dbl;
    logic [IRQ_N-1:0]   pend_rot;
    logic [4:0]         sel_off;
    logic [5:0]         sel_sum;
    logic [4:0]         sel_idx;
    logic               sel_found;
    logic [4:0]         rr_next;

    always_comb begin
        case (cfg_interrupt_msi_mmenable)
            3'd0:    fold_mask = 5'h00;
            3'd1:    fold_mask = 5'h01;
            3'd2:    fold_mask = 5'h03;
            3'd3:    fold_mask = 5'h07;
            3'd4:    fold_mask = 5'h0f;
            default: fold_mask = 5'h1f;
        endcase
    end

    // Rotate pending so the rr pointer sits at bit 0; the lowest set bit is the winner.
    assign pend_dbl = {pending_reg, pending_reg} >> rr_reg;
    assign pend_rot = pend_dbl[IRQ_N-1:0];

    always_comb begin
        sel_off = '0;
        for (int i = IRQ_N - 1; i >= 0; i--) begin
            if (pend_rot[i]) begin
                sel_off = 5'(i);
            end
        end
    end

    assign sel_found = |pending_reg;
    assign sel_sum   = {1'b0, rr_reg} + {1'b0, sel_off};
    assign sel_idx   = (sel_sum >= 6'(IRQ_N)) ? 5'(sel_sum - 6'(IRQ_N)) : 5'(sel_sum);
    assign rr_next   = (sel_reg == 5'(IRQ_N - 1)) ? 5'd0 : sel_reg + 5'd1;

    assign fail_event = (state_reg == WAIT) && !cfg_interrupt_msi_sent &&
                        (cfg_interrupt_msi_fail || (cnt_reg == '0));

    generate
        for (genvar gi = 0; gi < IRQ_N; gi++) begin : g_src
            assign clr_mask[gi] = (state_reg == ISSUE) && ((5'(gi) & mask_reg) == vec_reg);
            assign fail_set[gi] = fail_event && (sel_reg == 5'(gi));
        end

        for (genvar gi = 0; gi < 32; gi++) begin : g_vec
            logic [IRQ_N-1:0] member;
            for (genvar gj = 0; gj < IRQ_N; gj++) begin : g_member
                assign member[gj] = ((5'(gj) & fold_mask) == 5'(gi));
            end
            assign status_next[gi] = |(pending_reg & member);
        end
    endgenerate

    // A fresh request or a failed retry re-arms the bit even if it is being cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= (pending_reg & ~clr_mask) | irq_req | fail_set;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_reg      <= '0;
            status_d_reg    <= '0;
            data_enable_reg <= 1'b0;
        end else begin
            status_reg      <= status_next;
            status_d_reg    <= status_reg;
            data_enable_reg <= (status_reg != status_d_reg);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            rr_reg        <= '0;
            sel_reg       <= '0;
            vec_reg       <= '0;
            mask_reg      <= '0;
            cnt_reg       <= '0;
            msi_int_reg   <= '0;
            stat_sent_reg <= 1'b0;
            stat_fail_reg <= 1'b0;
        end else begin
            msi_int_reg   <= '0;
            stat_sent_reg <= 1'b0;
            stat_fail_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // msi_int is launched here so it is high exactly for the ISSUE cycle.
                    if (cfg_interrupt_msi_enable && sel_found) begin
                        sel_reg     <= sel_idx;
                        vec_reg     <= sel_idx & fold_mask;
                        mask_reg    <= fold_mask;
                        msi_int_reg <= 32'd1 << (sel_idx & fold_mask);
                        state_reg   <= ISSUE;
                    end
                end
                ISSUE: begin
                    rr_reg    <= rr_next;
                    cnt_reg   <= CNT_W'(TIMEOUT - 1);
                    state_reg <= WAIT;
                end
                WAIT: begin
                    if (cfg_interrupt_msi_sent) begin
                        stat_sent_reg <= 1'b1;
                        cnt_reg       <= CNT_W'(holdoff_cycles);
                        state_reg     <= (holdoff_cycles == '0) ? IDLE : HOLDOFF;
                    end else if (fail_event) begin
                        stat_fail_reg <= 1'b1;
                        cnt_reg       <= CNT_W'(RETRY_DELAY - 1);
                        state_reg     <= BACKOFF;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                BACKOFF, HOLDOFF: begin
                    if (cnt_reg == '0) begin
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign cfg_interrupt_msi_int                        = msi_int_reg;
    assign cfg_interrupt_msi_pending_status             = status_reg;
    assign cfg_interrupt_msi_pending_status_data_enable = data_enable_reg;
    assign busy                                         = (state_reg != IDLE);
    assign stat_sent                                    = stat_sent_reg;
    assign stat_fail                                    = stat_fail_reg;

endmodule
